aha_clock_gate_ctrl: RTL

//  Enable-side controller for the AhaClockGate ICG cell: generates the E and TE inputs of one ICG.

---
 rtl/aha_clock_gate_ctrl_pkg.sv | 15 +
 rtl/aha_cg_idle_counter.sv | 27 ++
 rtl/aha_clock_gate_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/aha_clock_gate_ctrl_pkg.sv
// Shared state encoding and default sizing for the ICG enable controller.
package aha_clock_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      CG_RUN    = 2'd0,
      CG_COUNT  = 2'd1,
      CG_GATED  = 2'd2,
      CG_UNGATE = 2'd3
   } cg_state_t;

   localparam int IDLE_W_DEF    = 8;
   localparam int WAKE_HOLD_DEF = 2;
   localparam int STAT_W_DEF    = 32;

endpackage

// File: rtl/aha_cg_idle_counter.sv
// Loadable down-counter with zero flag; times both the idle threshold and the wake hold.
module aha_cg_idle_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/aha_clock_gate_ctrl.sv
// Drives E/TE of one ICG: idle-timed or power-controller-forced gating, held-open ungating.
// Define AHA_CG_STATS_EN to add the saturating GATED_CYCLES statistic.
module aha_clock_gate_ctrl
   import aha_clock_gate_ctrl_pkg::*;
#(
   parameter int IDLE_W    = IDLE_W_DEF,
   parameter int WAKE_HOLD = WAKE_HOLD_DEF
`ifdef AHA_CG_STATS_EN
   ,
   parameter int STAT_W    = STAT_W_DEF
`endif
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              AUTO_EN,
   input  logic [IDLE_W-1:0] IDLE_CFG,
   input  logic              IDLE,
   input  logic              WAKE,
   input  logic              PWR_REQ,
   output logic              PWR_ACK,
   input  logic              SCAN_MODE,
   output logic              GATE_E,
   output logic              GATE_TE,
   output logic              GATED
`ifdef AHA_CG_STATS_EN
   ,
   output logic [STAT_W-1:0] GATED_CYCLES
`endif
);

   localparam logic [IDLE_W-1:0] HOLD_LD = IDLE_W'(WAKE_HOLD - 1);

   cg_state_t         state, state_nxt;
   logic              forced, forced_nxt;
   logic              cnt_load, cnt_dec, cnt_zero;
   logic [IDLE_W-1:0] cnt_load_val, idle_thr;
   logic              gate_e_nxt, gated_nxt, ack_nxt;

   // A threshold of 0 behaves like 1 so gating always needs at least one idle sample.
   assign idle_thr = (IDLE_CFG == '0) ? '0 : IDLE_CFG - IDLE_W'(1);

   aha_cg_idle_counter #(.W(IDLE_W)) u_cnt (
      .clk      (CLK),
      .rst      (RESET),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= CG_RUN;
         forced <= 1'b0;
      end else begin
         state  <= state_nxt;
         forced <= forced_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      forced_nxt   = forced;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      cnt_load_val = idle_thr;
      case (state)
         CG_RUN: begin
            if (PWR_REQ) begin
               state_nxt  = CG_GATED;
               forced_nxt = 1'b1;
            end else if (AUTO_EN && IDLE && !WAKE) begin
               state_nxt = CG_COUNT;
               cnt_load  = 1'b1;
            end
         end
         CG_COUNT: begin
            if (PWR_REQ) begin
               state_nxt  = CG_GATED;
               forced_nxt = 1'b1;
            end else if (!IDLE || WAKE || !AUTO_EN) begin
               state_nxt = CG_RUN;
            end else if (cnt_zero) begin
               state_nxt  = CG_GATED;
               forced_nxt = 1'b0;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         CG_GATED: begin
            // A forced gate only leaves on request release; wake/idle matter only for auto gates.
            if (PWR_REQ) begin
               forced_nxt = 1'b1;
            end else if (forced || WAKE || !IDLE || !AUTO_EN) begin
               state_nxt    = CG_UNGATE;
               forced_nxt   = 1'b0;
               cnt_load     = 1'b1;
               cnt_load_val = HOLD_LD;
            end
         end
         CG_UNGATE: begin
            if (PWR_REQ) begin
               state_nxt  = CG_GATED;
               forced_nxt = 1'b1;
            end else if (cnt_zero) begin
               state_nxt = CG_RUN;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_nxt  = CG_RUN;
            forced_nxt = 1'b0;
         end
      endcase
   end

   always_comb begin
      gated_nxt  = (state_nxt == CG_GATED);
      gate_e_nxt = !gated_nxt;
      ack_nxt    = gated_nxt && forced_nxt;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         GATE_E  <= 1'b1;
         GATED   <= 1'b0;
         PWR_ACK <= 1'b0;
      end else begin
         GATE_E  <= gate_e_nxt;
         GATED   <= gated_nxt;
         PWR_ACK <= ack_nxt;
      end
   end

   assign GATE_TE = SCAN_MODE;

`ifdef AHA_CG_STATS_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         GATED_CYCLES <= '0;
      end else if (GATED && (GATED_CYCLES != '1)) begin
         GATED_CYCLES <= GATED_CYCLES + STAT_W'(1);
      end
   end
`endif

endmodule
